// File: rtl/jpeg_pkg.sv
// -----------------------------------------------------------------------------
// jpeg_pkg
// Shared types and sizing helpers for the jpegCode pixel pipeline.
//   dctPort_t   : valid/data pair used between DCT stages
//   blk_mode_e  : block replay order of the transpose buffer
//   blk_words() : number of samples in an N x N block
//   blk_cnt_w() : width of a counter that walks one N x N block
// -----------------------------------------------------------------------------
package jpeg_pkg;

  localparam int unsigned DCT_PORT_W = 16;

  typedef struct packed {
    logic                  valid;
    logic [DCT_PORT_W-1:0] data;
  } dctPort_t;

  typedef enum logic {
    BLK_PASS      = 1'b0,
    BLK_TRANSPOSE = 1'b1
  } blk_mode_e;

  function automatic int unsigned blk_words(input int unsigned n);
    return n * n;
  endfunction

  function automatic int unsigned blk_cnt_w(input int unsigned n);
    return $clog2(n * n);
  endfunction

endpackage

// File: rtl/dct_bank_ram.sv
// -----------------------------------------------------------------------------
// dct_bank_ram
// Simple dual-port RAM holding one block: one write port and one read port
// whose data is registered (1-cycle read latency). Read data holds its value
// while i_rd_en is low, so it can serve as a stalled pipeline stage.
//   clk        : clock
//   i_wr_en    : write strobe
//   i_wr_addr  : write address
//   i_wr_data  : write data
//   i_rd_en    : read strobe, loads o_rd_data on the next rising edge
//   i_rd_addr  : read address
//   o_rd_data  : registered read data
// -----------------------------------------------------------------------------
module dct_bank_ram
  import jpeg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  i_wr_en,
  input  logic [AW-1:0]         i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  input  logic [AW-1:0]         i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/dct_transpose_buffer.sv
// -----------------------------------------------------------------------------
// dct_transpose_buffer
// Ping-pong N x N block buffer between the row and column 1-D DCT passes.
// Samples arrive row-major; each block is replayed transposed or unchanged,
// chosen by in_mode sampled with the block's first sample.
//   clk, rst_n            : clock, async active-low reset
//   in_valid/in_ready     : input handshake
//   in_data, in_mode      : sample, replay mode (1 = transpose)
//   out_valid/out_ready   : output handshake
//   out_data              : sample
//   out_first/out_last    : first / last sample of a block
// Read path: issue (address into RAM read register) -> output register.
// Both stages advance together, so a stall freezes the whole read pipe.
// -----------------------------------------------------------------------------
module dct_transpose_buffer
  import jpeg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BLK_N      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_first,
  output logic                  out_last
);

  localparam int unsigned DEPTH = blk_words(BLK_N);
  localparam int unsigned CW    = blk_cnt_w(BLK_N);
  localparam int unsigned HW    = CW / 2;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH - 1);

  logic [CW-1:0]         r_wr_cnt, r_rd_cnt;
  logic                  r_wr_bank, r_rd_bank;
  logic [1:0]            r_full, r_mode;
  logic                  r_s1_valid, r_s1_bank, r_s1_first, r_s1_last;
  logic                  r_out_valid, r_out_first, r_out_last;
  logic [DATA_WIDTH-1:0] r_out_data;

  logic                  w_in_acc, w_wr_last, w_adv, w_rd_issue, w_rd_last;
  logic [HW-1:0]         w_rd_row, w_rd_col;
  logic [CW-1:0]         w_rd_addr;
  logic [1:0]            w_full_d;
  logic [DATA_WIDTH-1:0] w_rd_data [2];

  assign in_ready  = !r_full[r_wr_bank];
  assign w_in_acc  = in_valid && in_ready;
  assign w_wr_last = w_in_acc && (r_wr_cnt == CNT_MAX);

  // Output register empty or being consumed: whole read pipe may move.
  assign w_adv      = !r_out_valid || out_ready;
  assign w_rd_issue = r_full[r_rd_bank] && w_adv;
  assign w_rd_last  = w_rd_issue && (r_rd_cnt == CNT_MAX);

  // rd_cnt = {row, col}; transposed address is col*N + row = {col, row}.
  assign w_rd_row  = r_rd_cnt[CW-1:HW];
  assign w_rd_col  = r_rd_cnt[HW-1:0];
  assign w_rd_addr = (r_mode[r_rd_bank] == BLK_TRANSPOSE) ? {w_rd_col, w_rd_row} : r_rd_cnt;

  // Set and clear always target different banks when both fire.
  always_comb begin
    w_full_d = r_full;
    if (w_wr_last) w_full_d[r_wr_bank] = 1'b1;
    if (w_rd_last) w_full_d[r_rd_bank] = 1'b0;
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    dct_bank_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .AW         (CW)
    ) u_ram (
      .clk       (clk),
      .i_wr_en   (w_in_acc && (r_wr_bank == 1'(b))),
      .i_wr_addr (r_wr_cnt),
      .i_wr_data (in_data),
      .i_rd_en   (w_rd_issue && (r_rd_bank == 1'(b))),
      .i_rd_addr (w_rd_addr),
      .o_rd_data (w_rd_data[b])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_cnt  <= '0;
      r_wr_bank <= 1'b0;
      r_mode    <= '0;
    end else if (w_in_acc) begin
      r_wr_cnt <= r_wr_cnt + 1'b1;
      if (r_wr_cnt == '0) r_mode[r_wr_bank] <= in_mode;
      if (w_wr_last) r_wr_bank <= ~r_wr_bank;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_cnt  <= '0;
      r_rd_bank <= 1'b0;
    end else if (w_rd_issue) begin
      r_rd_cnt <= r_rd_cnt + 1'b1;
      if (w_rd_last) r_rd_bank <= ~r_rd_bank;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_full <= '0;
    else        r_full <= w_full_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_bank   <= 1'b0;
      r_s1_first  <= 1'b0;
      r_s1_last   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_first <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (w_adv) begin
      r_s1_valid  <= w_rd_issue;
      r_s1_bank   <= r_rd_bank;
      r_s1_first  <= (r_rd_cnt == '0);
      r_s1_last   <= (r_rd_cnt == CNT_MAX);
      r_out_valid <= r_s1_valid;
      r_out_data  <= w_rd_data[r_s1_bank];
      r_out_first <= r_s1_valid && r_s1_first;
      r_out_last  <= r_s1_valid && r_s1_last;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_first = r_out_first;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_dct_transpose_buffer.sv
module tb_dct_transpose_buffer;

  localparam int N  = 8;
  localparam int NN = N * N;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, in_mode, out_valid, out_ready, out_first, out_last;
  logic [7:0] in_data, out_data;

  logic        s_in_valid, s_in_ready, s_in_mode, s_out_valid, s_out_ready;
  logic        s_out_first, s_out_last;
  logic [11:0] s_in_data, s_out_data;

  always #5 clk = ~clk;

  dct_transpose_buffer #(.DATA_WIDTH(8), .BLK_N(8)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_first (out_first),
    .out_last  (out_last)
  );

  dct_transpose_buffer #(.DATA_WIDTH(12), .BLK_N(4)) u_dut_small (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .in_data   (s_in_data),
    .in_mode   (s_in_mode),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .out_data  (s_out_data),
    .out_first (s_out_first),
    .out_last  (s_out_last)
  );

  typedef struct packed {logic [7:0] d; logic m;} src_t;
  typedef struct packed {logic [7:0] d; logic f; logic l;} exp_t;

  src_t src_q[$];
  exp_t exp_q[$];

  logic [7:0] m_blk [NN];
  int         m_cnt;
  logic       m_mode;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int in_rate, out_rate, acc_cnt;
  int t_last_acc, t_first_valid, bubbles, ready_drops;
  bit seen_valid, track;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: collect a whole block, then list it in replay order.
  task automatic model_accept(input logic [7:0] d, input logic md);
    if (m_cnt == 0) m_mode = md;
    m_blk[m_cnt] = d;
    m_cnt++;
    if (m_cnt == NN) begin
      for (int i = 0; i < NN; i++) begin
        int idx;
        idx = m_mode ? (i % N) * N + i / N : i;
        exp_q.push_back('{d: m_blk[idx], f: (i == 0), l: (i == NN - 1)});
      end
      m_cnt      = 0;
      t_last_acc = cyc + 1;
    end
  endtask

  task automatic drive();
    in_valid = (src_q.size() > 0) && ($urandom_range(99) < in_rate);
    if (in_valid) begin
      in_data = src_q[0].d;
      in_mode = src_q[0].m;
    end else begin
      in_data = 8'($urandom);
      in_mode = 1'($urandom);
    end
    out_ready = ($urandom_range(99) < out_rate);
  endtask

  task automatic cycle();
    @(negedge clk);
    if (in_valid && in_ready) begin
      model_accept(in_data, in_mode);
      void'(src_q.pop_front());
      acc_cnt++;
    end
    if (track && in_valid && !in_ready) ready_drops++;
    if (out_valid && !seen_valid) begin
      seen_valid    = 1'b1;
      t_first_valid = cyc;
    end
    if (track && seen_valid && !out_valid && exp_q.size() > 0) bubbles++;
    if (out_valid && out_ready) begin
      check_eq("exp_avail", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq("out_data", out_data, e.d);
        check_eq("out_first", out_first, e.f);
        check_eq("out_last", out_last, e.l);
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    drive();
  endtask

  // Non-first samples carry random modes, which the DUT must ignore.
  task automatic add_block(input logic md, input bit rnd, input int base, input int cnt);
    for (int k = 0; k < cnt; k++) begin
      src_t s;
      s.d = rnd ? 8'($urandom) : 8'(base + k);
      s.m = (k == 0) ? md : 1'($urandom);
      src_q.push_back(s);
    end
  endtask

  task automatic drain(input string tag);
    int g;
    g = 0;
    drive();
    while ((src_q.size() > 0 || exp_q.size() > 0) && g < 20000) begin
      cycle();
      g++;
    end
    check_eq({tag, "_done"}, src_q.size() + exp_q.size(), 0);
    repeat (4) cycle();
    check_eq({tag, "_idle"}, out_valid, 0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = 1'b0; out_ready = 1'b0;
    s_in_valid = 1'b0; s_in_data = '0; s_in_mode = 1'b1; s_out_ready = 1'b1;
    m_cnt = 0; m_mode = 1'b0; acc_cnt = 0; track = 1'b0; seen_valid = 1'b0;
    t_last_acc = 0; t_first_valid = 0; bubbles = 0; ready_drops = 0;
    in_rate = 100; out_rate = 100;
    #2;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_first", out_first, 0);
    check_eq("rst_out_last", out_last, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Transposed block with in_data = k, then the same block pass-through.
    add_block(1'b1, 1'b0, 0, NN);
    seen_valid = 1'b0;
    drain("t_order");
    check_eq("latency", t_first_valid - t_last_acc, 2);
    add_block(1'b0, 1'b0, 0, NN);
    drain("p_order");

    // Back-to-back blocks: no input stall, no output bubble.
    add_block(1'b1, 1'b1, 0, NN);
    add_block(1'b0, 1'b1, 0, NN);
    add_block(1'b1, 1'b1, 0, NN);
    add_block(1'b0, 1'b1, 0, NN);
    seen_valid = 1'b0; bubbles = 0; ready_drops = 0; track = 1'b1;
    drain("b2b");
    track = 1'b0;
    check_eq("b2b_bubbles", bubbles, 0);
    check_eq("b2b_ready_drops", ready_drops, 0);

    // Back-pressure: two banks fill, third block stalls.
    out_rate = 0; acc_cnt = 0;
    for (int b = 0; b < 3; b++) add_block(1'b1, 1'b1, 0, NN);
    drive();
    for (int i = 0; i < 200; i++) cycle();
    check_eq("bp_accepts", acc_cnt, 128);
    check_eq("bp_in_ready", in_ready, 0);
    check_eq("bp_out_valid", out_valid, 1);
    check_eq("bp_out_first", out_first, 1);
    check_eq("bp_hold_data0", out_data, exp_q[0].d);
    repeat (7) cycle();
    check_eq("bp_hold_data1", out_data, exp_q[0].d);
    check_eq("bp_hold_first", out_first, 1);
    out_rate = 100;
    drain("bp");
    check_eq("bp_total_acc", acc_cnt, 192);

    // Random stalls on both sides, random modes and data.
    in_rate = 50; out_rate = 50;
    for (int b = 0; b < 20; b++) add_block(1'($urandom), 1'b1, 0, NN);
    drain("rnd");

    // Reset after 30 samples of the second block.
    in_rate = 100; out_rate = 100; acc_cnt = 0;
    add_block(1'($urandom), 1'b1, 0, NN);
    add_block(1'($urandom), 1'b1, 0, 30);
    drive();
    for (int g = 0; g < 500 && acc_cnt < NN + 30; g++) cycle();
    check_eq("rst_mid_acc", acc_cnt, NN + 30);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_out_valid", out_valid, 0);
    check_eq("rst_mid_in_ready", in_ready, 1);
    check_eq("rst_mid_out_last", out_last, 0);
    src_q.delete(); exp_q.delete(); m_cnt = 0; in_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    add_block(1'b1, 1'b0, 0, NN);
    drain("post_rst");

    // 4x4 block, 12-bit samples on the second instance.
    begin
      int sent, got, g, ev;
      sent = 0; got = 0; g = 0;
      s_in_valid = 1'b1; s_in_data = 12'h800;
      while (got < 16 && g < 200) begin
        @(negedge clk);
        if (s_in_valid && s_in_ready) sent++;
        if (s_out_valid) begin
          ev = 'h800 + (got % 4) * 4 + got / 4;
          check_eq("n4_data", s_out_data, ev);
          check_eq("n4_first", s_out_first, got == 0);
          check_eq("n4_last", s_out_last, got == 15);
          got++;
        end
        @(posedge clk);
        #1;
        s_in_valid = (sent < 16);
        s_in_data  = 12'(12'h800 + sent);
        g++;
      end
      check_eq("n4_count", got, 16);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
